// File: rtl/rx_pkg.sv
// Shared definitions for the RX deserializer: default frame width and FSM state encoding.
// The PARITY state only exists when RX_DESER_PARITY_EN is defined.
package rx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

`ifdef RX_DESER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} deser_state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} deser_state_e;
`endif

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: XOR-reduce of the data word, inverted for odd parity.
module parity_calc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             odd,
    output logic             parity
);

    // Expected parity bit makes the total count of ones even (odd=0) or odd (odd=1).
    assign parity = (^data) ^ odd;

endmodule

// File: rtl/rx_deserializer.sv
// LSB-first serial-to-parallel frame assembler driven by a per-bit strobe.
// Define RX_DESER_PARITY_EN to add a trailing parity bit with ParityType/ParityError ports.
module rx_deserializer
    import rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SampledBit,
    input  logic                  BitStrobe,
    input  logic                  DeserEn,
    output logic [DATA_WIDTH-1:0] ParallelData,
    output logic                  DataValid,
    output logic                  Busy
`ifdef RX_DESER_PARITY_EN
    ,
    input  logic                  ParityType,
    output logic                  ParityError
`endif
);

    localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    deser_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] shifted;

    // New bit enters at the MSB so that after DATA_WIDTH strobes bit 0 sits at the LSB.
    assign shifted = (shift_q >> 1) | (DATA_WIDTH'(SampledBit) << (DATA_WIDTH - 1));

`ifdef RX_DESER_PARITY_EN
    logic perr_q, perr_d;
    logic exp_parity;

    parity_calc #(
        .WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data   (shift_q),
        .odd    (ParityType),
        .parity (exp_parity)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef RX_DESER_PARITY_EN
        perr_d  = 1'b0;
`endif
        case (state_q)
            StIdle, StShift: begin
                if (!DeserEn) begin
                    // Abort (or stay idle): partial frame is dropped, output word untouched.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (BitStrobe) begin
                    shift_d = shifted;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
`ifdef RX_DESER_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StIdle;
                        data_d  = shifted;
                        valid_d = 1'b1;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StShift;
                    end
                end
            end
`ifdef RX_DESER_PARITY_EN
            StParity: begin
                if (!DeserEn) begin
                    state_d = StIdle;
                end else if (BitStrobe) begin
                    state_d = StIdle;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    perr_d  = SampledBit ^ exp_parity;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef RX_DESER_PARITY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign ParityError = perr_q;
`endif

    assign ParallelData = data_q;
    assign DataValid    = valid_q;
    assign Busy         = (state_q != StIdle);

endmodule

// File: tb/tb_rx_deserializer.sv
// Randomized self-checking bench for rx_deserializer (default build, no parity),
// compared every cycle against a queue-based frame model.
module tb_rx_deserializer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         SampledBit = 1'b0;
    logic         BitStrobe = 1'b0;
    logic         DeserEn = 1'b0;
    logic [W-1:0] ParallelData;
    logic         DataValid;
    logic         Busy;

    rx_deserializer #(
        .DATA_WIDTH (W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .SampledBit   (SampledBit),
        .BitStrobe    (BitStrobe),
        .DeserEn      (DeserEn),
        .ParallelData (ParallelData),
        .DataValid    (DataValid),
        .Busy         (Busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Model: bits collected so far in the current frame, last completed word, pulse flag.
    bit           bits_q[$];
    logic [W-1:0] exp_data = '0;
    logic         exp_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic en, input logic stb, input logic b);
        exp_valid = 1'b0;
        if (!en) begin
            bits_q.delete();
        end else if (stb) begin
            bits_q.push_back(b);
            if (bits_q.size() == W) begin
                for (int i = 0; i < W; i++) exp_data[i] = bits_q[i];
                exp_valid = 1'b1;
                bits_q.delete();
            end
        end
    endtask

    task automatic cycle(input string tag, input logic en, input logic stb, input logic b);
        DeserEn    = en;
        BitStrobe  = stb;
        SampledBit = b;
        @(posedge CLK);
        model_edge(en, stb, b);
        #1;
        if (DataValid === 1'b1) pulses++;
        check_eq({tag, "_data"}, 32'(ParallelData), 32'(exp_data));
        check_eq({tag, "_valid"}, 32'(DataValid), 32'(exp_valid));
        check_eq({tag, "_busy"}, 32'(Busy), 32'(bits_q.size() != 0));
    endtask

    // Gaps before bit 0 may carry strobes with DeserEn=0, which must be ignored.
    task automatic send_frame(input string tag, input logic [W-1:0] word, input int max_gap,
                              input bit noise);
        for (int i = 0; i < W; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                if (noise && i == 0) cycle(tag, 1'b0, 1'($urandom), 1'($urandom));
                else cycle(tag, 1'b1, 1'b0, 1'($urandom));
            end
            cycle(tag, 1'b1, 1'b1, word[i]);
        end
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b0;
        #2;
        check_eq({tag, "_data"}, 32'(ParallelData), 32'h0);
        check_eq({tag, "_valid"}, 32'(DataValid), 32'h0);
        check_eq({tag, "_busy"}, 32'(Busy), 32'h0);
        bits_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        @(posedge CLK);
        #1;
        check_eq({tag, "_held_data"}, 32'(ParallelData), 32'h0);
        check_eq({tag, "_held_busy"}, 32'(Busy), 32'h0);
        RST = 1'b1;
    endtask

    initial begin
        int p0;
        #3;
        do_reset("reset");

        // 1,0,1,0,0,1,0,1 LSB-first
        p0 = pulses;
        send_frame("a5", 8'hA5, 0, 1'b0);
        cycle("a5_after", 1'b1, 1'b0, 1'b0);
        check_eq("a5_word", 32'(ParallelData), 32'hA5);
        check_eq("a5_pulses", 32'(pulses - p0), 32'd1);

        p0 = pulses;
        send_frame("b2b0", 8'h00, 0, 1'b0);
        send_frame("b2b1", 8'hFF, 0, 1'b0);
        cycle("b2b_after", 1'b1, 1'b0, 1'b0);
        check_eq("b2b_word", 32'(ParallelData), 32'hFF);
        check_eq("b2b_pulses", 32'(pulses - p0), 32'd2);

        p0 = pulses;
        for (int i = 0; i < 4; i++) cycle("abort", 1'b1, 1'b1, 1'($urandom));
        cycle("abort_drop", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("ignored", 1'b0, 1'b1, 1'b1);
        send_frame("3c", 8'h3C, 0, 1'b0);
        cycle("3c_after", 1'b1, 1'b0, 1'b0);
        check_eq("3c_word", 32'(ParallelData), 32'h3C);
        check_eq("3c_pulses", 32'(pulses - p0), 32'd1);

        p0 = pulses;
        send_frame("5a", 8'h5A, 5, 1'b1);
        repeat (3) cycle("5a_idle", 1'b1, 1'b0, 1'($urandom));
        check_eq("5a_word", 32'(ParallelData), 32'h5A);
        check_eq("5a_pulses", 32'(pulses - p0), 32'd1);

        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b1, 1'($urandom));
        do_reset("mid_rst");
        send_frame("81", 8'h81, 2, 1'b0);
        cycle("81_after", 1'b1, 1'b0, 1'b0);
        check_eq("81_word", 32'(ParallelData), 32'h81);

        for (int f = 0; f < 30; f++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, W - 1)) cycle("rnd_part", 1'b1, 1'b1, 1'($urandom));
                cycle("rnd_abort", 1'b0, 1'($urandom), 1'($urandom));
            end
            send_frame("rnd", w, 3, 1'b1);
            repeat ($urandom_range(0, 2)) cycle("rnd_idle", 1'b1, 1'b0, 1'($urandom));
            check_eq("rnd_word", 32'(ParallelData), 32'(w));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
